// File: rtl/mem_arb_pkg.sv
// Shared constants and types for the instruction/data memory port arbiter.
// RV32I load/store width encodings and the grant identifier.
package mem_arb_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic {
      GRANT_IF = 1'b0,
      GRANT_D  = 1'b1
   } grant_t;

endpackage

// File: rtl/align_check.sv
// Combinational alignment check for one access: byte never faults,
// halfword faults on an odd address, anything wider must be word aligned.
module align_check
   import mem_arb_pkg::*;
(
   input  logic [2:0] i_funct3,
   input  logic [1:0] i_addr_lo,
   output logic       o_misaligned
);

   always_comb begin
      o_misaligned = 1'b0;
      case (i_funct3)
         F3_B, F3_BU: o_misaligned = 1'b0;
         F3_H, F3_HU: o_misaligned = i_addr_lo[0];
         default:     o_misaligned = (i_addr_lo != 2'b00);
      endcase
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-cycle-latency memory between instruction fetch and
// load/store; misaligned requests are answered locally with an error.
module mem_port_arbiter
   import mem_arb_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        if_req_valid,
   input  logic [31:0] if_addr,
   output logic        if_req_ready,
   output logic        if_rsp_valid,
   output logic [31:0] if_rsp_data,
   output logic        if_rsp_err,
   input  logic        d_req_valid,
   input  logic        d_req_write,
   input  logic [2:0]  d_funct3,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_req_ready,
   output logic        d_rsp_valid,
   output logic        d_rsp_err,
   output logic [31:0] d_rsp_data,
   output logic        mem_write_mem,
   output logic [2:0]  mem_funct3,
   output logic [31:0] mem_write_address,
   output logic [31:0] mem_write_data,
   output logic [31:0] mem_read_address,
   input  logic [31:0] mem_read_data
);

   logic   w_if_mis;
   logic   w_d_mis;
   logic   w_if_rd;
   logic   w_d_rd;
   logic   w_d_st;
   logic   w_contend;
   logic   w_grant_d_rd;
   logic   w_grant_if;
   grant_t r_last_grant;
   logic   r_rsp_if;
   logic   r_rsp_if_err;
   logic   r_rsp_d;
   logic   r_rsp_d_err;
   logic   r_rsp_d_zero;

   align_check u_if_align (
      .i_funct3     (F3_W),
      .i_addr_lo    (if_addr[1:0]),
      .o_misaligned (w_if_mis)
   );

   align_check u_d_align (
      .i_funct3     (d_funct3),
      .i_addr_lo    (d_addr[1:0]),
      .o_misaligned (w_d_mis)
   );

   assign w_if_rd   = if_req_valid & ~w_if_mis;
   assign w_d_rd    = d_req_valid & ~d_req_write & ~w_d_mis;
   assign w_d_st    = d_req_valid & d_req_write & ~w_d_mis;
   assign w_contend = w_if_rd & w_d_rd;

   // Only one read port: contended reads alternate. A sub-word store cannot
   // share the cycle with a fetch because the memory has a single funct3.
   assign w_grant_d_rd = w_d_rd & (~w_if_rd | (r_last_grant == GRANT_IF));
   assign w_grant_if   = w_if_rd & ~w_grant_d_rd & ~(w_d_st & (d_funct3 != F3_W));

   assign if_req_ready = ~rst & if_req_valid & (w_if_mis | w_grant_if);
   assign d_req_ready  = ~rst & d_req_valid & (w_d_mis | d_req_write | w_grant_d_rd);

   always_comb begin
      mem_write_mem     = 1'b0;
      mem_funct3        = F3_W;
      mem_write_address = '0;
      mem_write_data    = '0;
      mem_read_address  = '0;
      if (!rst) begin
         if (w_d_st) begin
            mem_write_mem     = 1'b1;
            mem_write_address = d_addr;
            mem_write_data    = d_wdata;
            mem_funct3        = d_funct3;
         end
         if (w_grant_d_rd) begin
            mem_funct3       = d_funct3;
            mem_read_address = d_addr;
         end else if (w_grant_if) begin
            mem_read_address = if_addr;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rsp_if     <= 1'b0;
         r_rsp_if_err <= 1'b0;
         r_rsp_d      <= 1'b0;
         r_rsp_d_err  <= 1'b0;
         r_rsp_d_zero <= 1'b0;
         r_last_grant <= GRANT_IF;
      end else begin
         r_rsp_if     <= if_req_ready;
         r_rsp_if_err <= if_req_ready & w_if_mis;
         r_rsp_d      <= d_req_ready;
         r_rsp_d_err  <= d_req_ready & w_d_mis;
         r_rsp_d_zero <= d_req_ready & (w_d_mis | d_req_write);
         if (w_contend)
            r_last_grant <= w_grant_d_rd ? GRANT_D : GRANT_IF;
      end
   end

   assign if_rsp_valid = r_rsp_if;
   assign if_rsp_err   = r_rsp_if_err;
   assign if_rsp_data  = (r_rsp_if & ~r_rsp_if_err) ? mem_read_data : '0;
   assign d_rsp_valid  = r_rsp_d;
   assign d_rsp_err    = r_rsp_d_err;
   assign d_rsp_data   = (r_rsp_d & ~r_rsp_d_zero) ? mem_read_data : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table with a response scoreboard, a
// byte-addressed memory model, and a hand-written reset-abort sequence.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   logic        clk;
   logic        rst;
   logic        if_req_valid;
   logic [31:0] if_addr;
   logic        if_req_ready;
   logic        if_rsp_valid;
   logic [31:0] if_rsp_data;
   logic        if_rsp_err;
   logic        d_req_valid;
   logic        d_req_write;
   logic [2:0]  d_funct3;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_req_ready;
   logic        d_rsp_valid;
   logic        d_rsp_err;
   logic [31:0] d_rsp_data;
   logic        mem_write_mem;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_write_address;
   logic [31:0] mem_write_data;
   logic [31:0] mem_read_address;
   logic [31:0] mem_read_data;

   int total = 0;
   int bad   = 0;

   mem_port_arbiter dut (
      .clk               (clk),
      .rst               (rst),
      .if_req_valid      (if_req_valid),
      .if_addr           (if_addr),
      .if_req_ready      (if_req_ready),
      .if_rsp_valid      (if_rsp_valid),
      .if_rsp_data       (if_rsp_data),
      .if_rsp_err        (if_rsp_err),
      .d_req_valid       (d_req_valid),
      .d_req_write       (d_req_write),
      .d_funct3          (d_funct3),
      .d_addr            (d_addr),
      .d_wdata           (d_wdata),
      .d_req_ready       (d_req_ready),
      .d_rsp_valid       (d_rsp_valid),
      .d_rsp_err         (d_rsp_err),
      .d_rsp_data        (d_rsp_data),
      .mem_write_mem     (mem_write_mem),
      .mem_funct3        (mem_funct3),
      .mem_write_address (mem_write_address),
      .mem_write_data    (mem_write_data),
      .mem_read_address  (mem_read_address),
      .mem_read_data     (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory model (mem_bytes) and the bench's own shadow copy (exp_bytes)
   logic [7:0] mem_bytes [0:255];
   logic [7:0] exp_bytes [0:255];
   logic       mem_init;

   function automatic logic [7:0] init_byte(input int i);
      return 8'((i * 37 + 11) & 255);
   endfunction

   function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] lo,
                                           input logic [2:0] f3);
      logic [7:0]  b;
      logic [15:0] h;
      b = w[{lo, 3'b000} +: 8];
      h = w[{lo[1], 4'b0000} +: 16];
      case (f3)
         F3_B:    return {{24{b[7]}}, b};
         F3_BU:   return {24'h0, b};
         F3_H:    return {{16{h[15]}}, h};
         F3_HU:   return {16'h0, h};
         default: return w;
      endcase
   endfunction

   function automatic logic [31:0] word_mem(input logic [31:0] a);
      return {mem_bytes[{a[7:2], 2'd3}], mem_bytes[{a[7:2], 2'd2}],
              mem_bytes[{a[7:2], 2'd1}], mem_bytes[{a[7:2], 2'd0}]};
   endfunction

   function automatic logic [31:0] word_exp(input logic [31:0] a);
      return {exp_bytes[{a[7:2], 2'd3}], exp_bytes[{a[7:2], 2'd2}],
              exp_bytes[{a[7:2], 2'd1}], exp_bytes[{a[7:2], 2'd0}]};
   endfunction

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 256; i++) mem_bytes[i] <= init_byte(i);
      end else begin
         mem_read_data <= extract(word_mem(mem_read_address), mem_read_address[1:0], mem_funct3);
         if (mem_write_mem) begin
            case (mem_funct3)
               F3_B: mem_bytes[mem_write_address[7:0]] <= mem_write_data[7:0];
               F3_H: begin
                  mem_bytes[mem_write_address[7:0]]        <= mem_write_data[7:0];
                  mem_bytes[mem_write_address[7:0] + 8'd1] <= mem_write_data[15:8];
               end
               default: begin
                  for (int k = 0; k < 4; k++)
                     mem_bytes[{mem_write_address[7:2], 2'(k)}] <= mem_write_data[8*k +: 8];
               end
            endcase
         end
      end
   end

   function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
      if (f3 == F3_B || f3 == F3_BU) return 1'b0;
      if (f3 == F3_H || f3 == F3_HU) return lo[0];
      return lo != 2'b00;
   endfunction

   task automatic store_exp(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      case (f3)
         F3_B: exp_bytes[a[7:0]] = wd[7:0];
         F3_H: begin
            exp_bytes[a[7:0]]        = wd[7:0];
            exp_bytes[a[7:0] + 8'd1] = wd[15:8];
         end
         default: for (int k = 0; k < 4; k++) exp_bytes[{a[7:2], 2'(k)}] = wd[8*k +: 8];
      endcase
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic        if_v;
      logic [31:0] if_a;
      logic        d_v;
      logic        d_w;
      logic [2:0]  f3;
      logic [31:0] d_a;
      logic [31:0] wd;
      logic        e_ifr;
      logic        e_dr;
      logic        e_we;
      logic [2:0]  e_f3;
      logic [31:0] e_ra;
   } vec_t;

   typedef struct packed {
      logic        err;
      logic [31:0] data;
   } rsp_t;

   rsp_t q_if[$];
   rsp_t q_d[$];
   vec_t vecs [20];

   function automatic vec_t mk(input logic if_v, input logic [31:0] if_a, input logic d_v,
                               input logic d_w, input logic [2:0] f3, input logic [31:0] d_a,
                               input logic [31:0] wd, input logic e_ifr, input logic e_dr,
                               input logic e_we, input logic [2:0] e_f3, input logic [31:0] e_ra);
      return '{if_v, if_a, d_v, d_w, f3, d_a, wd, e_ifr, e_dr, e_we, e_f3, e_ra};
   endfunction

   task automatic drive(input vec_t v);
      if_req_valid = v.if_v;
      if_addr      = v.if_a;
      d_req_valid  = v.d_v;
      d_req_write  = v.d_w;
      d_funct3     = v.f3;
      d_addr       = v.d_a;
      d_wdata      = v.wd;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      rsp_t e;
      drive(v);
      #1;
      check({tag, ".if_ready"}, 32'(if_req_ready), 32'(v.e_ifr));
      check({tag, ".d_ready"}, 32'(d_req_ready), 32'(v.e_dr));
      check({tag, ".mem_we"}, 32'(mem_write_mem), 32'(v.e_we));
      check({tag, ".mem_f3"}, 32'(mem_funct3), 32'(v.e_f3));
      check({tag, ".mem_raddr"}, mem_read_address, v.e_ra);
      check({tag, ".mem_waddr"}, mem_write_address, v.e_we ? v.d_a : 32'h0);
      check({tag, ".mem_wdata"}, mem_write_data, v.e_we ? v.wd : 32'h0);
      if (v.e_ifr) begin
         e.err  = misaligned(F3_W, v.if_a[1:0]);
         e.data = e.err ? 32'h0 : word_exp(v.if_a);
         q_if.push_back(e);
      end
      if (v.e_dr) begin
         e.err  = misaligned(v.f3, v.d_a[1:0]);
         e.data = (e.err || v.d_w) ? 32'h0 : extract(word_exp(v.d_a), v.d_a[1:0], v.f3);
         q_d.push_back(e);
         if (v.d_w && !e.err) store_exp(v.f3, v.d_a, v.wd);
      end
      @(posedge clk);
      #1;
      if (q_if.size() > 0) begin
         e = q_if.pop_front();
         check({tag, ".if_rsp_valid"}, 32'(if_rsp_valid), 32'd1);
         check({tag, ".if_rsp_err"}, 32'(if_rsp_err), 32'(e.err));
         check({tag, ".if_rsp_data"}, if_rsp_data, e.data);
      end else begin
         check({tag, ".if_rsp_valid"}, 32'(if_rsp_valid), 32'd0);
      end
      if (q_d.size() > 0) begin
         e = q_d.pop_front();
         check({tag, ".d_rsp_valid"}, 32'(d_rsp_valid), 32'd1);
         check({tag, ".d_rsp_err"}, 32'(d_rsp_err), 32'(e.err));
         check({tag, ".d_rsp_data"}, d_rsp_data, e.data);
      end else begin
         check({tag, ".d_rsp_valid"}, 32'(d_rsp_valid), 32'd0);
      end
      $display("%s: if_rdy=%0d d_rdy=%0d if_rsp=%0d/%h d_rsp=%0d/%0d/%h", tag, v.e_ifr, v.e_dr,
               if_rsp_valid, if_rsp_data, d_rsp_valid, d_rsp_err, d_rsp_data);
   endtask

   initial begin
      // fetch stream; contended reads (D,IF,D,IF); sb stalls fetch; lbu; sw+fetch;
      // misaligned lw; misaligned fetch must not consume the alternation
      vecs[0]  = mk(1, 32'h00, 0, 0, F3_W,  32'h00, 32'h0,        1, 0, 0, F3_W,  32'h00);
      vecs[1]  = mk(1, 32'h04, 0, 0, F3_W,  32'h00, 32'h0,        1, 0, 0, F3_W,  32'h04);
      vecs[2]  = mk(1, 32'h08, 0, 0, F3_W,  32'h00, 32'h0,        1, 0, 0, F3_W,  32'h08);
      vecs[3]  = mk(1, 32'h20, 1, 0, F3_H,  32'h42, 32'h0,        0, 1, 0, F3_H,  32'h42);
      vecs[4]  = mk(1, 32'h20, 1, 0, F3_H,  32'h42, 32'h0,        1, 0, 0, F3_W,  32'h20);
      vecs[5]  = mk(1, 32'h20, 1, 0, F3_H,  32'h42, 32'h0,        0, 1, 0, F3_H,  32'h42);
      vecs[6]  = mk(1, 32'h20, 1, 0, F3_H,  32'h42, 32'h0,        1, 0, 0, F3_W,  32'h20);
      vecs[7]  = mk(1, 32'h30, 1, 1, F3_B,  32'h10, 32'hA5A5A5C3, 0, 1, 1, F3_B,  32'h00);
      vecs[8]  = mk(1, 32'h30, 0, 0, F3_W,  32'h00, 32'h0,        1, 0, 0, F3_W,  32'h30);
      vecs[9]  = mk(0, 32'h00, 1, 0, F3_BU, 32'h10, 32'h0,        0, 1, 0, F3_BU, 32'h10);
      vecs[10] = mk(1, 32'h34, 1, 1, F3_W,  32'h18, 32'h12345678, 1, 1, 1, F3_W,  32'h34);
      vecs[11] = mk(0, 32'h00, 1, 0, F3_W,  32'h18, 32'h0,        0, 1, 0, F3_W,  32'h18);
      vecs[12] = mk(0, 32'h00, 1, 0, F3_W,  32'h06, 32'h0,        0, 1, 0, F3_W,  32'h00);
      vecs[13] = mk(1, 32'h38, 1, 0, F3_W,  32'h06, 32'h0,        1, 1, 0, F3_W,  32'h38);
      vecs[14] = mk(1, 32'h3A, 1, 0, F3_W,  32'h44, 32'h0,        1, 1, 0, F3_W,  32'h44);
      vecs[15] = mk(1, 32'h3C, 1, 0, F3_W,  32'h48, 32'h0,        0, 1, 0, F3_W,  32'h48);
      vecs[16] = mk(1, 32'h3C, 1, 0, F3_W,  32'h48, 32'h0,        1, 0, 0, F3_W,  32'h3C);
      vecs[17] = mk(0, 32'h00, 1, 0, F3_HU, 32'h45, 32'h0,        0, 1, 0, F3_W,  32'h00);
      vecs[18] = mk(0, 32'h00, 1, 1, F3_H,  32'h11, 32'h0000FFFF, 0, 1, 0, F3_W,  32'h00);
      vecs[19] = mk(0, 32'h00, 0, 0, F3_W,  32'h00, 32'h0,        0, 0, 0, F3_W,  32'h00);

      for (int i = 0; i < 256; i++) exp_bytes[i] = init_byte(i);

      // reset with requests asserted: nothing may be accepted or written
      rst = 1'b1;
      mem_init = 1'b1;
      drive(mk(1, 32'h0, 1, 1, F3_W, 32'h0, 32'hFFFFFFFF, 0, 0, 0, F3_W, 32'h0));
      repeat (2) @(posedge clk);
      #1;
      check("rst.if_ready", 32'(if_req_ready), 32'd0);
      check("rst.d_ready", 32'(d_req_ready), 32'd0);
      check("rst.mem_we", 32'(mem_write_mem), 32'd0);
      check("rst.if_rsp_valid", 32'(if_rsp_valid), 32'd0);
      check("rst.d_rsp_valid", 32'(d_rsp_valid), 32'd0);
      check("rst.if_rsp_err", 32'(if_rsp_err), 32'd0);
      check("rst.d_rsp_err", 32'(d_rsp_err), 32'd0);
      mem_init = 1'b0;
      rst = 1'b0;
      drive(vecs[19]);

      for (int i = 0; i < 20; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // data wins a contended read (last_grant -> D), then reset kills its response
      drive(mk(1, 32'h50, 1, 0, F3_W, 32'h60, 32'h0, 0, 0, 0, F3_W, 32'h0));
      #1;
      check("ra.d_ready", 32'(d_req_ready), 32'd1);
      check("ra.if_ready", 32'(if_req_ready), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      drive(mk(1, 32'h50, 1, 1, F3_W, 32'h60, 32'hDEADBEEF, 0, 0, 0, F3_W, 32'h0));
      #1;
      check("ra.rst_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
      check("ra.rst_if_ready", 32'(if_req_ready), 32'd0);
      check("ra.rst_d_ready", 32'(d_req_ready), 32'd0);
      check("ra.rst_mem_we", 32'(mem_write_mem), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(vecs[19]);
      #1;
      check("ra.post_d_rsp_valid", 32'(d_rsp_valid), 32'd0);
      check("ra.post_if_rsp_valid", 32'(if_rsp_valid), 32'd0);
      $display("reset-abort: d_rsp_valid=%0d if_rsp_valid=%0d", d_rsp_valid, if_rsp_valid);
      run_vec(mk(1, 32'h50, 1, 0, F3_W, 32'h60, 32'h0, 0, 1, 0, F3_W, 32'h60), "post_rst");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
